// File: rtl/dual_ad_operand_feeder_if.sv
// Request channel into the dual A/D pre-adder operand feeder.
// The master drives an operand pair and op code; the slave accepts on valid & ready.
interface dual_ad_operand_feeder_if #(
  parameter int A_W = 30,
  parameter int D_W = 25
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [D_W-1:0] in_d;
  logic [1:0]     in_op;

  modport master (output in_valid, in_a, in_d, in_op, input in_ready);
  modport slave  (input in_valid, in_a, in_d, in_op, output in_ready);
endinterface

// File: rtl/dual_ad_operand_feeder.sv
// Buffers operand requests, drives pre-adder A/D/INMODE/CEs and realigns a result-valid/tag strobe.
// Optional overflow checker enabled by defining DUAL_AD_OVF_CHECK_EN.
module dual_ad_operand_feeder #(
  parameter int A_W        = 30,
  parameter int D_W        = 25,
  parameter int PIPE_DEPTH = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dual_ad_operand_feeder_if.slave req,
  input  logic                   hold,
  output logic [A_W-1:0]         A,
  output logic [D_W-1:0]         D,
  output logic [3:0]             inmode,
  output logic                   CEA1,
  output logic                   CEA2,
  output logic                   CED,
  output logic                   CEAD,
  output logic                   res_valid,
  output logic [3:0]             res_tag,
  output logic                   ovf_flag,
  output logic                   busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DRAIN} state_t;

  logic [A_W-1:0] mem_a [FIFO_DEPTH];
  logic [D_W-1:0] mem_d [FIFO_DEPTH];
  logic [1:0]     mem_op [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           full, empty, push, issue;
  logic [A_W-1:0] head_a;
  logic [D_W-1:0] head_d;
  logic [1:0]     head_op;
  logic [3:0]     inmode_next;
  logic [3:0]     tag_reg;
  logic           ce_reg;
  logic           issue_ovf;
  logic           pipe_busy;
  state_t         state_reg, state_next, ret_state_reg, ret_state_next;

  logic [PIPE_DEPTH-1:0] valid_pipe_reg, valid_pipe_next;
  logic [3:0]            tag_pipe_reg  [PIPE_DEPTH];
  logic [3:0]            tag_pipe_next [PIPE_DEPTH];

  // in_ready depends only on the registered count, never on in_valid
  assign full         = (count_reg == CW'(FIFO_DEPTH));
  assign empty        = (count_reg == '0);
  assign req.in_ready = rst_n & ~full;
  assign push         = req.in_valid & req.in_ready;
  assign issue        = ~hold & ~empty;
  assign pipe_busy    = |valid_pipe_reg;

  assign head_a  = mem_a[rd_ptr_reg];
  assign head_d  = mem_d[rd_ptr_reg];
  assign head_op = mem_op[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg]  <= req.in_a;
      mem_d[wr_ptr_reg]  <= req.in_d;
      mem_op[wr_ptr_reg] <= req.in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)  wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (issue) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, issue})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
    end
  end

  // INMODE is {in3 subtract, in2 use D, in1 gate A off, in0 A1/A2 select}
  always_comb begin
    inmode_next = 4'b0000;
    case (head_op)
      2'b01:   inmode_next = 4'b0100;
      2'b10:   inmode_next = 4'b1100;
      2'b11:   inmode_next = 4'b0110;
      default: inmode_next = 4'b0000;
    endcase
  end

  // CEs stay up through drain bubbles so in-flight results keep moving through the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A       <= '0;
      D       <= '0;
      inmode  <= '0;
      ce_reg  <= 1'b0;
      tag_reg <= '0;
    end else begin
      ce_reg <= ~hold & (~empty | pipe_busy);
      if (issue) begin
        A       <= head_a;
        D       <= head_d;
        inmode  <= inmode_next;
        tag_reg <= tag_reg + 4'd1;
      end
    end
  end

  assign CEA1 = ce_reg;
  assign CEA2 = ce_reg;
  assign CED  = ce_reg;
  assign CEAD = ce_reg;

  assign valid_pipe_next[0] = issue;
  assign tag_pipe_next[0]   = tag_reg;
  genvar gi;
  generate
    for (gi = 1; gi < PIPE_DEPTH; gi++) begin : g_pipe
      assign valid_pipe_next[gi] = valid_pipe_reg[gi-1];
      assign tag_pipe_next[gi]   = tag_pipe_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe_reg <= '0;
      tag_pipe_reg   <= '{default: '0};
    end else if (!hold) begin
      valid_pipe_reg <= valid_pipe_next;
      tag_pipe_reg   <= tag_pipe_next;
    end
  end

  assign res_valid = valid_pipe_reg[PIPE_DEPTH-1];
  assign res_tag   = tag_pipe_reg[PIPE_DEPTH-1];

`ifdef DUAL_AD_OVF_CHECK_EN
  logic signed [D_W:0]   d_ext, a_ext, res_ext;
  logic [PIPE_DEPTH-1:0] ovf_pipe_reg, ovf_pipe_next;

  assign d_ext = {head_d[D_W-1], head_d};
  assign a_ext = {head_a[D_W-1], head_a[D_W-1:0]};

  always_comb begin
    res_ext = d_ext;
    case (head_op)
      2'b00:   res_ext = a_ext;
      2'b01:   res_ext = d_ext + a_ext;
      2'b10:   res_ext = d_ext - a_ext;
      default: res_ext = d_ext;
    endcase
  end

  // Overflow when the extra sign bit disagrees with the D_W-bit result's sign
  assign issue_ovf        = res_ext[D_W] ^ res_ext[D_W-1];
  assign ovf_pipe_next[0] = issue_ovf;
  generate
    for (gi = 1; gi < PIPE_DEPTH; gi++) begin : g_ovf
      assign ovf_pipe_next[gi] = ovf_pipe_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ovf_pipe_reg <= '0;
    else if (!hold) ovf_pipe_reg <= ovf_pipe_next;
  end

  assign ovf_flag = ovf_pipe_reg[PIPE_DEPTH-1];
`else
  assign issue_ovf = 1'b0;
  assign ovf_flag  = issue_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ret_state_reg <= RUN;
    end else begin
      state_reg     <= state_next;
      ret_state_reg <= ret_state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ret_state_next = ret_state_reg;
    case (state_reg)
      IDLE: if (push) state_next = RUN;
      RUN: begin
        if (hold) begin
          state_next     = HOLD;
          ret_state_next = RUN;
        end else if (empty && !push) begin
          state_next = pipe_busy ? DRAIN : IDLE;
        end
      end
      HOLD: if (!hold) state_next = ret_state_reg;
      DRAIN: begin
        if (hold) begin
          state_next     = HOLD;
          ret_state_next = DRAIN;
        end else if (push) begin
          state_next = RUN;
        end else if (empty && !pipe_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end
endmodule

// File: tb/tb_dual_ad_operand_feeder.sv
// Scoreboard bench for dual_ad_operand_feeder: stimulus queues expected results, a monitor
// pops and compares each new res_valid against a spec-level model.
module tb_dual_ad_operand_feeder;
  localparam int A_W        = 30;
  localparam int D_W        = 25;
  localparam int PIPE_DEPTH = 3;
  localparam int FIFO_DEPTH = 4;
`ifdef DUAL_AD_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic [A_W-1:0] A;
  logic [D_W-1:0] D;
  logic [3:0] inmode, res_tag;
  logic CEA1, CEA2, CED, CEAD, res_valid, ovf_flag, busy;

  always #5 clk = ~clk;

  dual_ad_operand_feeder_if #(.A_W(A_W), .D_W(D_W)) req_if ();

  dual_ad_operand_feeder #(.A_W(A_W), .D_W(D_W), .PIPE_DEPTH(PIPE_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_if.slave), .hold(hold),
    .A(A), .D(D), .inmode(inmode),
    .CEA1(CEA1), .CEA2(CEA2), .CED(CED), .CEAD(CEAD),
    .res_valid(res_valid), .res_tag(res_tag), .ovf_flag(ovf_flag), .busy(busy)
  );

  typedef struct {
    logic [A_W-1:0] a;
    logic [D_W-1:0] d;
    logic [3:0]     inmode;
    logic [3:0]     tag;
    logic           ovf;
  } exp_t;

  typedef struct packed {
    logic [3:0]     ce;
    logic [3:0]     inmode;
    logic [D_W-1:0] d;
    logic [A_W-1:0] a;
  } snap_t;

  exp_t  exp_q[$];
  snap_t hist[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accepted = 0;
  int n_results = 0;
  int last_res_cyc = 0;
  logic hold_at_edge = 1'b0;
  logic prev_valid = 1'b0;
  logic [3:0] prev_tag = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    hold_at_edge <= hold;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result: signed arithmetic on D and the low D_W bits of A, checked against range
  function automatic logic model_ovf(input logic [1:0] op, input logic [A_W-1:0] a, input logic [D_W-1:0] d);
    longint sa, sd, r, lim;
    logic [D_W-1:0] a_lo;
    a_lo = a[D_W-1:0];
    sa = longint'($signed(a_lo));
    sd = longint'($signed(d));
    case (op)
      2'b00:   r = sa;
      2'b01:   r = sd + sa;
      2'b10:   r = sd - sa;
      default: r = sd;
    endcase
    lim = longint'(1) << (D_W - 1);
    return OVF_EN && (r >= lim || r < -lim);
  endfunction

  function automatic void expect_req(input logic [1:0] op, input logic [A_W-1:0] a, input logic [D_W-1:0] d);
    exp_t e;
    int t;
    e.a = a;
    e.d = d;
    e.inmode = {op == 2'b10, op != 2'b00, op == 2'b11, 1'b0};
    t = accepted % 16;
    e.tag = t[3:0];
    e.ovf = model_ovf(op, a, d);
    exp_q.push_back(e);
    accepted++;
  endfunction

  task automatic push_req(input logic [1:0] op, input logic [A_W-1:0] a, input logic [D_W-1:0] d,
                          input int max_wait, output bit ok, output int acc_cyc);
    ok = 1'b0;
    acc_cyc = cyc;
    req_if.in_valid = 1'b1;
    req_if.in_op = op;
    req_if.in_a = a;
    req_if.in_d = d;
    for (int i = 0; i < max_wait && !ok; i++) begin
      if (req_if.in_ready) begin
        ok = 1'b1;
        expect_req(op, a, d);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    req_if.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: a result is new only when the last edge was not held
  always @(negedge clk) begin
    exp_t e;
    snap_t s;
    if (!rst_n) begin
      hist.delete();
      prev_valid = 1'b0;
      prev_tag = '0;
    end else begin
      if (hold_at_edge) begin
        check("hold_ce", 64'({CEA1, CEA2, CED, CEAD}), 64'(0));
        check("hold_res_valid", 64'(res_valid), 64'(prev_valid));
        check("hold_res_tag", 64'(res_tag), 64'(prev_tag));
      end else begin
        hist.push_back({{CEA1, CEA2, CED, CEAD}, inmode, D, A});
        if (hist.size() > 16) void'(hist.pop_front());
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: res_valid=1 tag=%0d, expected no result (cycle %0d)", res_tag, cyc);
          end else begin
            e = exp_q.pop_front();
            check("res_tag", 64'(res_tag), 64'(e.tag));
            check("ovf_flag", 64'(ovf_flag), 64'(e.ovf));
            if (hist.size() >= PIPE_DEPTH) begin
              s = hist[hist.size() - PIPE_DEPTH];
              check("issue_A", 64'(s.a), 64'(e.a));
              check("issue_D", 64'(s.d), 64'(e.d));
              check("issue_inmode", 64'(s.inmode), 64'(e.inmode));
              check("issue_ce", 64'(s.ce), 64'(4'hF));
            end else begin
              check("issue_history", 64'(hist.size()), 64'(PIPE_DEPTH));
            end
            n_results++;
            last_res_cyc = cyc;
          end
        end
      end
      prev_valid = res_valid;
      prev_tag = res_tag;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int p0, p1, base;
    logic [1:0] op;
    logic [A_W-1:0] a;
    logic [D_W-1:0] d;

    req_if.in_valid = 1'b0;
    req_if.in_a = '0;
    req_if.in_d = '0;
    req_if.in_op = '0;

    // Reset and idle
    step(2);
    check("in_ready_in_reset", 64'(req_if.in_ready), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("idle_res_valid", 64'(res_valid), 64'(0));
    end
    check("idle_in_ready", 64'(req_if.in_ready), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_ce", 64'({CEA1, CEA2, CED, CEAD}), 64'(0));
    check("idle_inmode", 64'(inmode), 64'(0));
    check("idle_tag", 64'(res_tag), 64'(0));

    // Single op01 and its latency
    push_req(2'b01, 30'd5, 25'd7, 4, ok, p0);
    check("single_accept", 64'(ok), 64'(1));
    step(1);
    check("single_inmode", 64'(inmode), 64'(4'b0100));
    check("single_ce", 64'({CEA1, CEA2, CED, CEAD}), 64'(4'hF));
    check("single_busy", 64'(busy), 64'(1));
    wait_drain();
    check("single_latency", 64'(last_res_cyc - p0), 64'(PIPE_DEPTH));

    // Back-to-back ops 10, 11, 00 give consecutive results
    base = n_results;
    push_req(2'b10, 30'd9, 25'd20, 4, ok, p0);
    push_req(2'b11, 30'd3, 25'd4, 4, ok, p1);
    push_req(2'b00, 30'h2AAAAAAA, 25'h1555555, 4, ok, p1);
    wait_drain();
    check("b2b_count", 64'(n_results - base), 64'(3));
    check("b2b_last_latency", 64'(last_res_cyc - p0), 64'(PIPE_DEPTH + 2));

    // Fill under hold: only FIFO_DEPTH accepted
    base = n_results;
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_req(2'(i), A_W'(100 + i), D_W'(200 + i), 1, ok, p1);
      check("fill_accept", 64'(ok), 64'(i < FIFO_DEPTH));
    end
    check("full_in_ready", 64'(req_if.in_ready), 64'(0));
    hold = 1'b0;
    wait_drain();
    check("fill_results", 64'(n_results - base), 64'(FIFO_DEPTH));
    check("fill_in_ready", 64'(req_if.in_ready), 64'(1));

    // Two-cycle hold while a result is in flight
    push_req(2'b01, 30'd11, 25'd13, 4, ok, p0);
    step(1);
    hold = 1'b1;
    step(2);
    hold = 1'b0;
    wait_drain();
    check("hold_latency", 64'(last_res_cyc - p0), 64'(PIPE_DEPTH + 2));

    // Overflow boundaries
    push_req(2'b01, 30'd1, 25'h0FFFFFF, 4, ok, p1);
    push_req(2'b10, 30'd1, 25'h0, 4, ok, p1);
    push_req(2'b10, 30'd1, 25'h1000000, 4, ok, p1);
    wait_drain();

    // Randomized traffic with random holds
    for (int i = 0; i < 400; i++) begin
      hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) != 0) begin
        op = 2'($urandom_range(0, 3));
        a = A_W'($urandom);
        d = D_W'($urandom);
        req_if.in_valid = 1'b1;
        req_if.in_op = op;
        req_if.in_a = a;
        req_if.in_d = d;
        if (req_if.in_ready) expect_req(op, a, d);
      end else begin
        req_if.in_valid = 1'b0;
      end
      step(1);
    end
    req_if.in_valid = 1'b0;
    hold = 1'b0;
    wait_drain();
    step(PIPE_DEPTH + 3);
    check("drained_busy", 64'(busy), 64'(0));

    // Reset with requests queued and in flight: nothing may emerge
    hold = 1'b1;
    for (int i = 0; i < 3; i++) push_req(2'b01, A_W'(i), D_W'(i), 2, ok, p1);
    hold = 1'b0;
    step(2);
    rst_n = 1'b0;
    exp_q.delete();
    accepted = 0;
    step(1);
    check("midreset_in_ready", 64'(req_if.in_ready), 64'(0));
    check("midreset_res_valid", 64'(res_valid), 64'(0));
    step(1);
    rst_n = 1'b1;
    step(8);
    check("postreset_busy", 64'(busy), 64'(0));
    check("postreset_in_ready", 64'(req_if.in_ready), 64'(1));
    push_req(2'b11, 30'd77, 25'd88, 4, ok, p0);
    wait_drain();
    check("postreset_latency", 64'(last_res_cyc - p0), 64'(PIPE_DEPTH));
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
